parity_checker: RTL and testbench

Receive-side counterpart of the byte parity generator. It accepts data words with an appended even-parity bit over a valid/ready stream and checks the parity. It forwards the data through a one-stage registered pipeline with a per-word error flag. It also keeps error statistics and raises a burst-error alarm for the link-monitor logic.

---
 rtl/parity_checker.sv | 85 ++++++++
 tb/tb_parity_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/parity_checker.sv
// parity_checker: even-parity check on a valid/ready stream with a 1-stage output register,
// saturating error statistics and a burst alarm. Define PARITY_DROP_EN to drop bad words.
module parity_checker #(
    parameter int DATA_W      = 8,
    parameter int CNT_W       = 16,
    parameter int BURST_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W:0]   in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    output logic [CNT_W-1:0]  err_count,
    output logic              err_sticky,
    output logic              alarm,
    input  logic              clr
);
    typedef enum logic {NORMAL, ALARM} state_t;

    state_t              state_q, state_d, state_base;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                perr_q, perr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_base;
    logic                sticky_q, sticky_d;
    logic [7:0]          burst_q, burst_d, burst_base;
    logic                accept, bad, bad_acc, load;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign bad      = ^in_word;
    assign bad_acc  = accept && bad;
`ifdef PARITY_DROP_EN
    assign load = accept && !bad;
`else
    assign load = accept;
`endif

    // Statistics are cleared first so a word accepted alongside clr counts afresh.
    always_comb begin
        out_valid_d = load || (out_valid_q && !out_ready);
        data_d      = load ? in_word[DATA_W:1] : data_q;
        perr_d      = load ? bad : perr_q;
        cnt_base    = clr ? '0 : cnt_q;
        burst_base  = clr ? 8'd0 : burst_q;
        state_base  = clr ? NORMAL : state_q;
        cnt_d       = (bad_acc && cnt_base != '1) ? cnt_base + 1'b1 : cnt_base;
        sticky_d    = (sticky_q && !clr) || bad_acc;
        burst_d     = !accept ? burst_base :
                      !bad ? 8'd0 :
                      (burst_base == 8'(BURST_LIMIT)) ? burst_base : burst_base + 8'd1;
        state_d     = (bad_acc && burst_d == 8'(BURST_LIMIT)) ? ALARM : state_base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            cnt_q       <= '0;
            sticky_q    <= 1'b0;
            burst_q     <= 8'd0;
            state_q     <= NORMAL;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            burst_q     <= burst_d;
            state_q     <= state_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = data_q;
    assign out_perr   = perr_q;
    assign err_count  = cnt_q;
    assign err_sticky = sticky_q;
    assign alarm      = (state_q == ALARM);
endmodule

// File: tb/tb_parity_checker.sv
// tb_parity_checker: two checker instances (default config, and CNT_W=3/BURST_LIMIT=1) on shared stimulus,
// compared against a run-length/total-count reference model, a directed vector table and hand sequences.
module tb_parity_checker;
    localparam int DW = 8;
`ifdef PARITY_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, out_ready, clr;
    logic [DW:0]   in_word;
    logic          a_in_ready, a_out_valid, a_out_perr, a_sticky, a_alarm;
    logic          b_in_ready, b_out_valid, b_out_perr, b_sticky, b_alarm;
    logic [DW-1:0] a_out_data, b_out_data;
    logic [15:0]   a_cnt;
    logic [2:0]    b_cnt;

    always #5 clk = ~clk;

    parity_checker #(.DATA_W(DW), .CNT_W(16), .BURST_LIMIT(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_word(in_word),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_perr(a_out_perr),
        .err_count(a_cnt), .err_sticky(a_sticky), .alarm(a_alarm), .clr(clr));

    parity_checker #(.DATA_W(DW), .CNT_W(3), .BURST_LIMIT(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_word(in_word),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data), .out_perr(b_out_perr),
        .err_count(b_cnt), .err_sticky(b_sticky), .alarm(b_alarm), .clr(clr));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: total bad words and current run of consecutive bad words since clr/reset.
    logic          m_valid, m_perr, m_stk, m_alm_a, m_alm_b;
    logic [DW-1:0] m_data;
    int            m_tot, m_run;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_perr = 1'b0; m_data = '0; m_stk = 1'b0;
        m_alm_a = 1'b0; m_alm_b = 1'b0; m_tot = 0; m_run = 0;
    endtask

    task automatic check_all();
        chk("a_out_valid", a_out_valid, m_valid);
        chk("b_out_valid", b_out_valid, m_valid);
        if (m_valid) begin
            chk("a_out_data", a_out_data, m_data);
            chk("b_out_data", b_out_data, m_data);
            chk("a_out_perr", a_out_perr, m_perr);
            chk("b_out_perr", b_out_perr, m_perr);
        end
        chk("a_err_count", a_cnt, (m_tot > 65535) ? 65535 : m_tot);
        chk("b_err_count", b_cnt, (m_tot > 7) ? 7 : m_tot);
        chk("a_err_sticky", a_sticky, m_stk);
        chk("b_err_sticky", b_sticky, m_stk);
        chk("a_alarm", a_alarm, m_alm_a);
        chk("b_alarm", b_alarm, m_alm_b);
        chk("a_in_ready", a_in_ready, !m_valid || out_ready);
        chk("b_in_ready", b_in_ready, !m_valid || out_ready);
    endtask

    task automatic cycle(input logic v, input logic r, input logic c, input logic [DW:0] w);
        logic acc, bad;
        check_all();
        in_valid = v; out_ready = r; clr = c; in_word = w;
        acc = v && (!m_valid || r);
        bad = ^w;
        if (c) begin
            m_tot = 0; m_run = 0; m_stk = 1'b0; m_alm_a = 1'b0; m_alm_b = 1'b0;
        end
        if (acc && bad) begin
            m_tot++; m_run++; m_stk = 1'b1;
        end else if (acc) m_run = 0;
        if (m_run >= 4) m_alm_a = 1'b1;
        if (m_run >= 1) m_alm_b = 1'b1;
        if (acc && (!bad || !DROP)) begin
            m_valid = 1'b1; m_data = w[DW:1]; m_perr = bad;
        end else if (r) m_valid = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        v, r, c;
        logic [DW:0] w;
        logic        chkd;
        logic [7:0]  d;
        int          cnt;
        logic        stk, alm;
    } vec_t;
    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 9'h14A, 1'b1, 8'hA5, 0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 9'h00F, 1'b1, 8'h07, 0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 9'h14B, 1'b0, 8'h00, 1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 9'h14B, 1'b0, 8'h00, 2, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 9'h14B, 1'b0, 8'h00, 3, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 9'h14A, 1'b1, 8'hA5, 3, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 9'h14B, 1'b0, 8'h00, 4, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 9'h14B, 1'b0, 8'h00, 5, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 9'h14B, 1'b0, 8'h00, 6, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 9'h14B, 1'b0, 8'h00, 7, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 9'h00F, 1'b1, 8'h07, 7, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 9'h14B, 1'b0, 8'h00, 1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 8'h00, 0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0; in_word = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].w);
            chk("tbl_cnt", a_cnt, tbl[i].cnt);
            chk("tbl_sticky", a_sticky, tbl[i].stk);
            chk("tbl_alarm", a_alarm, tbl[i].alm);
            if (tbl[i].chkd) begin
                chk("tbl_valid", a_out_valid, 1'b1);
                chk("tbl_data", a_out_data, tbl[i].d);
            end
        end
        chk("clr_bad_b_alarm", b_alarm, 1'b0);

        cycle(1'b1, 1'b0, 1'b0, 9'h14A);
        chk("bp_in_ready", a_in_ready, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 9'h00F);
            chk("bp_hold_data", a_out_data, 8'hA5);
            chk("bp_hold_ready", a_in_ready, 1'b0);
        end
        cycle(1'b1, 1'b1, 1'b0, 9'h00F);
        chk("bp_next_data", a_out_data, 8'h07);
        cycle(1'b0, 1'b1, 1'b0, 9'h000);
        chk("bp_drained", a_out_valid, 1'b0);

        cycle(1'b0, 1'b1, 1'b1, 9'h000);
        for (int k = 0; k < 9; k++) cycle(1'b1, 1'b1, 1'b0, 9'h14B);
        chk("sat_b_cnt", b_cnt, 3'd7);
        chk("sat_a_cnt", a_cnt, 16'd9);
        cycle(1'b1, 1'b0, 1'b0, 9'h14A);
        chk("pre_rst_valid", a_out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", a_out_valid, 1'b0);
        chk("rst_a_cnt", a_cnt, 16'd0);
        chk("rst_b_cnt", b_cnt, 3'd0);
        chk("rst_sticky", a_sticky, 1'b0);
        chk("rst_alarm", a_alarm, 1'b0);
        chk("rst_in_ready", a_in_ready, 1'b1);
        in_valid = 1'b0; out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 600; k++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 40) == 0, 9'($urandom));
        check_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
